mario_input_ctrl: RTL
=====================

# mario_input_ctrl

Input conditioning stage between the HPS I/O (PS/2 keyboard events, USB/DB9 joystick words) and the Mario Bros game core. It owns keyboard key-state tracking and left/right conflict resolution (last pressed wins). It also owns the user pause toggle and the pause-dim timer. It produces the active-low `I_SW1`/`I_SW2` switch bytes plus `pause` and `dim_video`, all registered, on the system clock.

## Interface
- `DIM_CYCLES`, 32'h1C9C3800: cycles of continuous pause before `dim_video` asserts (10 s @ 48 MHz).
- `COIN_CYCLES`, 2400000: minimum coin assertion length in cycles (50 ms), used only when the coin-stretch macro is defined.
- `clk_sys` in 1: system clock, 48 MHz. Every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-high.
- `ps2_key` in 11: `[10]` toggles once per key event; `[9]` is 1 = press; `[8:0]` is the scan code, where `[8]` is the extended-prefix flag.
- `joy_0`, `joy_1` in 16 each, active-high: `[0]` R, `[1]` L, `[4]` fire, `[5]` start1, `[6]` start2, `[7]` coin, `[8]` pause.
- `hs_access` in 1: hiscore module is requesting a pause.
- `osd_pause` in 1: OSD is open and pause-on-OSD is enabled.
- `sw1` out 8: `{~test, ~start2, ~start1, ~fire, 1, 1, ~left, ~right}`.
- `sw2` out 8: `{1, 1, ~coin, ~fire2, 1, 1, ~left2, ~right2}`.
- `pause` out 1: game core pause request.
- `dim_video` out 1: halve the RGB output.

## Operation
- **Reset values.** `sw1`=8'hFF, `sw2`=8'hFF, `pause`=0, `dim_video`=0. All key registers, the 2-way state, `pause_toggle`, the dim timer and the coin counter clear to 0. The toggle history loads the current `ps2_key[10]`, so reset never produces a spurious key event.
- **Keyboard events.**
  - An event is a `ps2_key[10]` value that differs from the history register. On an event, the matched key register takes `ps2_key[9]`.
  - For left/right the extended bit is ignored: x6B left, x74 right.
  - Exact codes: 029 space, 014 ctrl, 005 F1, 006 F2, 016 '1', 01E '2', 02E '5', 036 '6', 023 D (left2), 034 G (right2), 01C A (fire2), 02C T (test). Unmatched codes are ignored.
  - Space and ctrl are separate registers; fire = space | ctrl. This way, releasing one key while the other is held keeps fire asserted.
- **Merged signals.**
  - left = kbd_left | joy_0[1]; right = kbd_right | joy_0[0]. Player 2 uses D, G and `joy_1`.
  - fire2 = A | joy_1[4].
  - start1 = F1 | '1' | joy_0[5] | joy_1[5].
  - start2 = F2 | '2' | joy_0[6] | joy_1[6].
  - coin_raw = '5' | '6' | joy_0[7] | joy_1[7].
- **2-way resolver (one per player).**
  - Two sync stages: `in1 <= {L,R}`, `in2 <= in1`.
  - The new-press vector is `in1 & ~in2`. A new R sets `last_h`=01; a new L sets `last_h`=10. If both are new in the same cycle, L wins.
  - Registered output: `last_h` when `in1`==11, otherwise `in1`.
- **Pause.**
  - A rising edge of `joy_0[8] | joy_1[8]` flips `pause_toggle`.
  - `pause` is registered from `hs_access | pause_toggle | osd_pause`.
- **Dim timer (32 bit).**
  - Cleared to 0 in any cycle where `pause`=0.
  - While `pause`=1 it increments each cycle and saturates at `DIM_CYCLES`.
  - `dim_video` is registered from (timer >= `DIM_CYCLES`).

## Timing
- Latency counts rising edges of `clk_sys` after the input change.
- Joystick buttons and coin reach `sw1`/`sw2` in 1 cycle.
- Joystick directions reach the outputs in 3 cycles (`in1`, resolver out, sw register).
- Keyboard non-direction keys reach the outputs 2 cycles after `ps2_key[10]` toggles.
- Keyboard directions reach the outputs 4 cycles after `ps2_key[10]` toggles.
- `hs_access`/`osd_pause` reach `pause` in 1 cycle; the joystick pause edge reaches `pause` in 2 cycles.
- `dim_video` rises `DIM_CYCLES`+1 cycles after `pause` rises. It falls 2 cycles after `pause` falls.
- A pause deassert mid-count clears the timer; no residual count is kept.
- A reset asserted mid-operation returns every output to its reset value on the next edge.

## Configuration
- **`MARIO_COIN_STRETCH_EN` defined.**
  - A rising edge of `coin_raw` loads a 24-bit counter with `COIN_CYCLES`-1, which then decrements to 0.
  - The coin bit is `coin_raw | (counter != 0)`.
  - A new rising edge while the counter is running reloads it.
- **Undefined.** The coin bit is `coin_raw`; the counter is absent.

## Test plan
- **Keyboard chord.** Space press, then ctrl press, then space release → `sw1[4]` stays 0; after ctrl release, `sw1`=8'hFF.
- **Left/right conflict.** `joy_0[0]`=1, then 5 cycles later `joy_0[1]`=1 → `sw1[1:0]`=01 (left wins); release L → `sw1[1:0]`=10 three cycles later.
- **Pause toggle.** `joy_1[8]` held high 10 cycles → `pause`=1 after 2 cycles and stays 1; a second press → `pause`=0; `hs_access`=1 alone → `pause`=1 after 1 cycle.
- **Dim timer** (`DIM_CYCLES`=16). Pause held → `dim_video`=1 at cycle 17; drop pause at cycle 20 → `dim_video`=0 by cycle 22; re-pause → another 17 cycles to dim.
- **Coin stretch** (`MARIO_COIN_STRETCH_EN`, `COIN_CYCLES`=8). 1-cycle `joy_0[7]` pulse → `sw2[5]`=0 for exactly 8 cycles; without the macro → low for 1 cycle.
- **Reset.** Reset mid-keypress with `ps2_key[10]` held toggled → after reset no key event occurs and `sw1`=`sw2`=8'hFF.

Source files
------------

// File: rtl/mario_input_ctrl.sv
// mario_input_ctrl: conditions keyboard and joystick input for the Mario Bros core.
// Tracks PS/2 key state, resolves left/right conflicts (last pressed wins),
// merges the keyboard and joystick sources into the active-low switch bytes,
// and owns the user pause toggle and the pause-dim timer.
// Optional feature macro: MARIO_COIN_STRETCH_EN (stretches short coin pulses).
module mario_input_ctrl #(
    parameter logic [31:0] DIM_CYCLES  = 32'h1C9C3800,
    parameter int unsigned COIN_CYCLES = 2400000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy_0,
    input  logic [15:0] joy_1,
    input  logic        hs_access,
    input  logic        osd_pause,
    output logic [7:0]  sw1,
    output logic [7:0]  sw2,
    output logic        pause,
    output logic        dim_video
);

    // Bit positions inside the keyboard key-state vector.
    localparam int K_LEFT   = 0;
    localparam int K_RIGHT  = 1;
    localparam int K_SPACE  = 2;
    localparam int K_CTRL   = 3;
    localparam int K_F1     = 4;
    localparam int K_F2     = 5;
    localparam int K_1      = 6;
    localparam int K_2      = 7;
    localparam int K_5      = 8;
    localparam int K_6      = 9;
    localparam int K_LEFT2  = 10;
    localparam int K_RIGHT2 = 11;
    localparam int K_FIRE2  = 12;
    localparam int K_TEST   = 13;

    localparam logic [23:0] COIN_LOAD = 24'(COIN_CYCLES - 32'd1);

    logic [13:0] keys_q, keys_d;
    logic        key_hist_q;
    logic        key_evt_s;

    logic [1:0]  in1_q [2];
    logic [1:0]  in2_q [2];
    logic [1:0]  last_q [2];
    logic [1:0]  last_d [2];
    logic [1:0]  dir_q [2];
    logic [1:0]  dir_d [2];
    logic [1:0]  dir_raw_s [2];

    logic        pjoy_s, pjoy_prev_q, toggle_q, toggle_d;
    logic [31:0] timer_q, timer_d;

    logic        fire_s, fire2_s, start1_s, start2_s, coin_raw_s, coin_s;
    logic [7:0]  sw1_q, sw1_d, sw2_q, sw2_d;
    logic        pause_q, pause_d, dim_q, dim_d;

    assign key_evt_s = (ps2_key[10] != key_hist_q);

    // Decode one PS/2 event into the key-state vector; directions ignore the extended flag.
    always_comb begin
        keys_d = keys_q;
        if (key_evt_s) begin
            if (ps2_key[7:0] == 8'h6B) begin
                keys_d[K_LEFT] = ps2_key[9];
            end else if (ps2_key[7:0] == 8'h74) begin
                keys_d[K_RIGHT] = ps2_key[9];
            end else begin
                case (ps2_key[8:0])
                    9'h029:  keys_d[K_SPACE]  = ps2_key[9];
                    9'h014:  keys_d[K_CTRL]   = ps2_key[9];
                    9'h005:  keys_d[K_F1]     = ps2_key[9];
                    9'h006:  keys_d[K_F2]     = ps2_key[9];
                    9'h016:  keys_d[K_1]      = ps2_key[9];
                    9'h01E:  keys_d[K_2]      = ps2_key[9];
                    9'h02E:  keys_d[K_5]      = ps2_key[9];
                    9'h036:  keys_d[K_6]      = ps2_key[9];
                    9'h023:  keys_d[K_LEFT2]  = ps2_key[9];
                    9'h034:  keys_d[K_RIGHT2] = ps2_key[9];
                    9'h01C:  keys_d[K_FIRE2]  = ps2_key[9];
                    9'h02C:  keys_d[K_TEST]   = ps2_key[9];
                    default: keys_d = keys_q;
                endcase
            end
        end else begin
            keys_d = keys_q;
        end
    end

    // Key state and event history; history reloads on reset so no phantom event follows.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            keys_q     <= 14'd0;
            key_hist_q <= ps2_key[10];
        end else begin
            keys_q     <= keys_d;
            key_hist_q <= ps2_key[10];
        end
    end

    // Raw {L,R} per player, keyboard OR joystick.
    always_comb begin
        dir_raw_s[0] = {keys_q[K_LEFT]  | joy_0[1], keys_q[K_RIGHT]  | joy_0[0]};
        dir_raw_s[1] = {keys_q[K_LEFT2] | joy_1[1], keys_q[K_RIGHT2] | joy_1[0]};
    end

    // Two-way resolver: remember the most recent new press; it wins while both are held.
    // The updated memory feeds the output so the first "both held" cycle is already correct.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (in1_q[p][1] && !in2_q[p][1]) begin
                last_d[p] = 2'b10;
            end else if (in1_q[p][0] && !in2_q[p][0]) begin
                last_d[p] = 2'b01;
            end else begin
                last_d[p] = last_q[p];
            end
            if (in1_q[p] == 2'b11) begin
                dir_d[p] = last_d[p];
            end else begin
                dir_d[p] = in1_q[p];
            end
        end
    end

    // Resolver synchronizer stages, memory and registered direction.
    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                in1_q[p]  <= 2'b00;
                in2_q[p]  <= 2'b00;
                last_q[p] <= 2'b00;
                dir_q[p]  <= 2'b00;
            end else begin
                in1_q[p]  <= dir_raw_s[p];
                in2_q[p]  <= in1_q[p];
                last_q[p] <= last_d[p];
                dir_q[p]  <= dir_d[p];
            end
        end
    end

    assign fire_s     = keys_q[K_SPACE] | keys_q[K_CTRL] | joy_0[4];
    assign fire2_s    = keys_q[K_FIRE2] | joy_1[4];
    assign start1_s   = keys_q[K_F1] | keys_q[K_1] | joy_0[5] | joy_1[5];
    assign start2_s   = keys_q[K_F2] | keys_q[K_2] | joy_0[6] | joy_1[6];
    assign coin_raw_s = keys_q[K_5] | keys_q[K_6] | joy_0[7] | joy_1[7];

`ifdef MARIO_COIN_STRETCH_EN
    logic        coin_prev_q;
    logic [23:0] coin_cnt_q, coin_cnt_d;

    // Coin stretch counter: (re)load on a coin rising edge, then count down to zero.
    always_comb begin
        if (coin_raw_s && !coin_prev_q) begin
            coin_cnt_d = COIN_LOAD;
        end else if (coin_cnt_q != 24'd0) begin
            coin_cnt_d = coin_cnt_q - 24'd1;
        end else begin
            coin_cnt_d = coin_cnt_q;
        end
        coin_s = coin_raw_s | (coin_cnt_q != 24'd0);
    end

    // Coin edge history and stretch counter state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_prev_q <= 1'b0;
            coin_cnt_q  <= 24'd0;
        end else begin
            coin_prev_q <= coin_raw_s;
            coin_cnt_q  <= coin_cnt_d;
        end
    end

    logic unused_s;
    assign unused_s = ^{joy_0[15:9], joy_0[3:2], joy_1[15:9], joy_1[3:2]};
`else
    assign coin_s = coin_raw_s;

    logic unused_s;
    assign unused_s = ^{joy_0[15:9], joy_0[3:2], joy_1[15:9], joy_1[3:2], COIN_LOAD};
`endif

    // Pause toggle, pause request and saturating dim timer next-state.
    always_comb begin
        pjoy_s   = joy_0[8] | joy_1[8];
        toggle_d = toggle_q ^ (pjoy_s & ~pjoy_prev_q);
        pause_d  = hs_access | toggle_q | osd_pause;
        if (!pause_q) begin
            timer_d = 32'd0;
        end else if (timer_q >= DIM_CYCLES) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 32'd1;
        end
        dim_d = (timer_q >= DIM_CYCLES);
    end

    // Active-low switch bytes assembled from merged signals.
    always_comb begin
        sw1_d = {~keys_q[K_TEST], ~start2_s, ~start1_s, ~fire_s, 1'b1, 1'b1, ~dir_q[0][1], ~dir_q[0][0]};
        sw2_d = {1'b1, 1'b1, ~coin_s, ~fire2_s, 1'b1, 1'b1, ~dir_q[1][1], ~dir_q[1][0]};
    end

    // Output registers plus pause/dim state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sw1_q       <= 8'hFF;
            sw2_q       <= 8'hFF;
            pause_q     <= 1'b0;
            dim_q       <= 1'b0;
            toggle_q    <= 1'b0;
            pjoy_prev_q <= 1'b0;
            timer_q     <= 32'd0;
        end else begin
            sw1_q       <= sw1_d;
            sw2_q       <= sw2_d;
            pause_q     <= pause_d;
            dim_q       <= dim_d;
            toggle_q    <= toggle_d;
            pjoy_prev_q <= pjoy_s;
            timer_q     <= timer_d;
        end
    end

    assign sw1       = sw1_q;
    assign sw2       = sw2_q;
    assign pause     = pause_q;
    assign dim_video = dim_q;

endmodule
